// File: rtl/stor_mem.sv
`default_nettype none
// ============================================================================
// Module      : stor_mem
// Description : Word-addressed storage array with one write port and two
//               independent registered read ports. Reads return the word
//               addressed on the previous edge; a read that collides with a
//               write to the same word returns the old contents.
//               Read data is forced to zero while rst_n is low. Memory
//               contents are never cleared by reset.
// Revision    : 1.0 - initial release
// ============================================================================
module stor_mem #(
    parameter int    ADDR_W    = 15,
    parameter int    DATA_W    = 16,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic [ADDR_W:1]   raddr0,
    output logic [DATA_W-1:0] rdata0,
    input  logic [ADDR_W:1]   raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              wen,
    input  logic [ADDR_W:1]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rst_n
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [0:c_DEPTH-1];
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              w_wr_en;

    // Writes are dropped on any edge where reset is held low.
    assign w_wr_en = wen & rst_n;

    // Write port: storage itself has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Read port 0: registered read; non-blocking update gives read-before-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata0 <= '0;
        end else begin
            r_rdata0 <= r_mem[raddr0];
        end
    end

    // Read port 1: identical to port 0, fully independent addressing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata1 <= '0;
        end else begin
            r_rdata1 <= r_mem[raddr1];
        end
    end

    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_stor_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_stor_mem
// Description : Self-checking bench for stor_mem: vector table plus directed
//               sequences for latency, persistence and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stor_mem;

   logic        clk;
   logic        rst_n;
   logic [15:1] raddr0;
   logic [15:1] raddr1;
   logic [15:1] waddr;
   logic [15:0] rdata0;
   logic [15:0] rdata1;
   logic [15:0] wdata;
   logic        wen;

   int n_checks;
   int n_fail;

   typedef struct {
      logic        wen;
      logic [15:1] waddr;
      logic [15:0] wdata;
      logic [15:1] raddr0;
      logic [15:1] raddr1;
      logic        chk0;
      logic [15:0] exp0;
      logic        chk1;
      logic [15:0] exp1;
   } vec_t;

   vec_t vecs [0:13];

   stor_mem dut (
      .clk    (clk),
      .raddr0 (raddr0),
      .rdata0 (rdata0),
      .raddr1 (raddr1),
      .rdata1 (rdata1),
      .wen    (wen),
      .waddr  (waddr),
      .wdata  (wdata),
      .rst_n  (rst_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [15:1] wa, input logic [15:0] wd,
                        input logic [15:1] ra0, input logic [15:1] ra1);
      wen    = we;
      waddr  = wa;
      wdata  = wd;
      raddr0 = ra0;
      raddr1 = ra1;
   endtask

   // Advance one rising edge and land just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b1;
      drive(1'b0, 15'h0, 16'h0, 15'h0, 15'h0);

      // Expected values assume memory state before that row's write.
      //            wen  waddr     wdata     ra0       ra1       c0  exp0      c1  exp1
      vecs[0]  = '{1'b1, 15'h0000, 16'h0032, 15'h0000, 15'h0002, 1'b0, 16'h0000, 1'b0, 16'h0000};
      vecs[1]  = '{1'b1, 15'h0002, 16'h0030, 15'h0000, 15'h0002, 1'b1, 16'h0032, 1'b0, 16'h0000};
      vecs[2]  = '{1'b0, 15'h0000, 16'hFFFF, 15'h0000, 15'h0002, 1'b1, 16'h0032, 1'b1, 16'h0030};
      vecs[3]  = '{1'b1, 15'h0005, 16'h1234, 15'h0000, 15'h0002, 1'b1, 16'h0032, 1'b1, 16'h0030};
      vecs[4]  = '{1'b1, 15'h0005, 16'hBEEF, 15'h0005, 15'h0005, 1'b1, 16'h1234, 1'b1, 16'h1234};
      vecs[5]  = '{1'b0, 15'h0005, 16'h0000, 15'h0005, 15'h0000, 1'b1, 16'hBEEF, 1'b1, 16'h0032};
      vecs[6]  = '{1'b1, 15'h7FFF, 16'hA5A5, 15'h0002, 15'h0005, 1'b1, 16'h0030, 1'b1, 16'hBEEF};
      vecs[7]  = '{1'b0, 15'h7FFF, 16'h5A5A, 15'h7FFF, 15'h7FFF, 1'b1, 16'hA5A5, 1'b1, 16'hA5A5};
      vecs[8]  = '{1'b1, 15'h0002, 16'h0001, 15'h0000, 15'h7FFF, 1'b1, 16'h0032, 1'b1, 16'hA5A5};
      vecs[9]  = '{1'b1, 15'h0002, 16'h0002, 15'h0002, 15'h0002, 1'b1, 16'h0001, 1'b1, 16'h0001};
      vecs[10] = '{1'b0, 15'h0002, 16'h0009, 15'h0002, 15'h0000, 1'b1, 16'h0002, 1'b1, 16'h0032};
      vecs[11] = '{1'b1, 15'h0003, 16'h1111, 15'h0000, 15'h0005, 1'b1, 16'h0032, 1'b1, 16'hBEEF};
      vecs[12] = '{1'b1, 15'h0004, 16'h2222, 15'h0003, 15'h0003, 1'b1, 16'h1111, 1'b1, 16'h1111};
      vecs[13] = '{1'b0, 15'h0004, 16'h0000, 15'h0003, 15'h0004, 1'b1, 16'h1111, 1'b1, 16'h2222};

      // Asynchronous reset at start: outputs forced to zero.
      #2 rst_n = 1'b0;
      #1;
      check("reset_rdata0", rdata0, 16'h0000);
      check("reset_rdata1", rdata1, 16'h0000);
      step();
      check("reset_hold_rdata0", rdata0, 16'h0000);
      check("reset_hold_rdata1", rdata1, 16'h0000);
      #2 rst_n = 1'b1;

      // Vector table.
      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].wen, vecs[i].waddr, vecs[i].wdata, vecs[i].raddr0, vecs[i].raddr1);
         step();
         if (vecs[i].chk0) check($sformatf("vec%0d_rdata0", i), rdata0, vecs[i].exp0);
         if (vecs[i].chk1) check($sformatf("vec%0d_rdata1", i), rdata1, vecs[i].exp1);
      end

      // Exactly one edge of read latency when the address changes.
      drive(1'b0, 15'h0, 16'h0, 15'h0000, 15'h0000);
      step();
      check("lat_pre", rdata0, 16'h0032);
      raddr0 = 15'h0002;
      #2;
      check("lat_before_edge", rdata0, 16'h0032);
      step();
      check("lat_after_edge", rdata0, 16'h0002);

      // Persistence over a long idle stretch.
      drive(1'b0, 15'h0, 16'h0, 15'h0000, 15'h0002);
      for (int i = 0; i < 50; i++) step();
      check("persist_rdata0", rdata0, 16'h0032);
      check("persist_rdata1", rdata1, 16'h0002);

      // Reset between edges with a write pending: outputs clear, write dropped.
      drive(1'b1, 15'h0000, 16'hDEAD, 15'h0000, 15'h7FFF);
      #2 rst_n = 1'b0;
      #1;
      check("midreset_rdata0", rdata0, 16'h0000);
      check("midreset_rdata1", rdata1, 16'h0000);
      step();
      step();
      check("midreset_hold_rdata0", rdata0, 16'h0000);
      check("midreset_hold_rdata1", rdata1, 16'h0000);
      // Release with a write presented: first edge after release behaves normally.
      drive(1'b1, 15'h0006, 16'h6666, 15'h0000, 15'h7FFF);
      #2 rst_n = 1'b1;
      step();
      check("post_reset_rdata0", rdata0, 16'h0032);
      check("post_reset_rdata1", rdata1, 16'hA5A5);
      drive(1'b0, 15'h0, 16'h0, 15'h0006, 15'h0005);
      step();
      check("first_write_after_reset", rdata0, 16'h6666);
      check("post_reset_addr5", rdata1, 16'hBEEF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
